pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//   Central stall/flush sequencer for the 5-stage pipeline registers (IF_ID, ID_EX, EX_MEM).
//   Detects load-use hazards, freezes the pipe on data-memory wait, and squashes wrong-path
//   instructions after an EX-stage redirect (MP). Drives per-stage enable/flush strobes and PC enable.
// PARAMETERS
//   REG_W        5   register-index width
//   FLUSH_CYCLES 2   cycles IF_ID+ID_EX are flushed after a redirect (1..15)
//   CNT_W        32  perf counter width (PERF_CNT_EN only)
// PORTS
//   clk          in   1      pipeline clock
//   reset        in   1      asynchronous, active-low reset
//   id_rs1       in   REG_W  RS1 of instruction in ID
//   id_rs2       in   REG_W  RS2 of instruction in ID
//   id_use_rs1   in   1      ID instruction reads RS1
//   id_use_rs2   in   1      ID instruction reads RS2
//   ex_rd        in   REG_W  RD of instruction in EX (ID_EX RD_out)
//   ex_rw        in   1      EX instruction writes RD (RW_out)
//   ex_md        in   1      EX instruction is a load (MD_out)
//   ex_mp        in   1      EX redirect / taken branch (MP_out)
//   mem_req      in   1      MEM stage has an outstanding data access
//   mem_ready    in   1      data memory completes access this cycle
//   pc_en        out  1      PC update enable
//   if_id_en     out  1      IF_ID load enable
//   if_id_flush  out  1      IF_ID load NOP
//   id_ex_en     out  1      ID_EX load enable
//   id_ex_flush  out  1      ID_EX load bubble (all control fields 0)
//   ex_mem_en    out  1      EX_MEM load enable
//   stall_cnt    out  CNT_W  total stall cycles (PERF_CNT_EN only)
// BEHAVIOUR
//   States: RUN, MEM_WAIT, FLUSH. Outputs Mealy (state + inputs); state/counters registered.
//   reset low: state=RUN, flush_cnt=0, redir_pend=0; outputs forced en=0, flush=1 (pipe held).
//   Priority each cycle: mem wait > redirect > load-use.
//   RUN, default: all *_en=1, flushes=0.
//   RUN, mem_req & !mem_ready: all *_en=0, flushes=0; -> MEM_WAIT; if ex_mp also, redir_pend<=1.
//   RUN, ex_mp: en=1, if_id_flush=id_ex_flush=1; flush_cnt<=FLUSH_CYCLES-1;
//     -> FLUSH if FLUSH_CYCLES>1, else stay RUN.
//   RUN, load-use (ex_md & ex_rw & ex_rd!=0 & ((id_use_rs1&id_rs1==ex_rd)|(id_use_rs2&id_rs2==ex_rd))):
//     pc_en=if_id_en=0, id_ex_flush=1, ex_mem_en=1; exactly one bubble; state stays RUN
//     (next cycle producer is in MEM, compare no longer hits).
//   MEM_WAIT: all *_en=0 until mem_ready; on mem_ready cycle en=1; redir_pend ? (apply
//     redirect flush this cycle, load flush_cnt, redir_pend<=0, -> FLUSH/RUN as above) : -> RUN.
//   FLUSH: if_id_flush=id_ex_flush=1, en=1; flush_cnt decrements; at 0 -> RUN.
//     New ex_mp in FLUSH is ignored (EX holds a bubble). Mem wait in FLUSH: freeze, counter holds,
//     -> MEM_WAIT with resume-to-FLUSH flag.
//   ex_rd==0 never hazards. flush while en=0 never asserted together with a freeze.
//   Reset mid-MEM_WAIT or mid-FLUSH: abandons sequence, pending redirect dropped.
// CONFIGURATION
//   PIPE_PERF_CNT_EN defined: stall_cnt increments (saturating at all-ones) every cycle with
//     pc_en=0 and reset high; reset clears to 0. Undefined: port absent, no counter logic.
// STRUCTURE
//   pipe_ctrl_pkg: state enum (RUN/MEM_WAIT/FLUSH), FLUSH_CNT_W=4, strobe bundle indices.
//   Sub-module pipe_load_use_det: combinational load-use comparator (RS1/RS2 vs ex_rd).
// TESTING
//   1 reset low, random inputs -> all en=0, flushes=1; release -> first cycle all en=1.
//   2 ex_md=1,ex_rw=1,ex_rd=5,id_rs1=5,id_use_rs1=1 -> 1 cycle pc_en=0,id_ex_flush=1, then normal.
//   3 same as 2 with ex_rd=0 or ex_rw=0 -> no stall.
//   4 ex_mp pulse, FLUSH_CYCLES=2 -> if_id_flush/id_ex_flush high 2 consecutive cycles, pc_en=1.
//   5 mem_req=1,mem_ready=0 for 3 cycles with ex_mp in cycle 1 -> 3 frozen cycles, then 2 flush cycles.
//   6 reset asserted during MEM_WAIT -> immediate held outputs; after release RUN, no flush.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Strobe bundle: one bit per pipeline-register control, indexed by the STB_* constants.
package pipe_ctrl_pkg;

    localparam int unsigned FLUSH_CNT_W = 4;

    typedef enum logic [1:0] {
        StRun,
        StMemWait,
        StFlush
    } pipe_state_t;

    localparam int unsigned STB_W           = 6;
    localparam int unsigned STB_PC_EN       = 0;
    localparam int unsigned STB_IF_ID_EN    = 1;
    localparam int unsigned STB_IF_ID_FLUSH = 2;
    localparam int unsigned STB_ID_EX_EN    = 3;
    localparam int unsigned STB_ID_EX_FLUSH = 4;
    localparam int unsigned STB_EX_MEM_EN   = 5;

    // Canned strobe patterns, bit order {ex_mem_en, id_ex_flush, id_ex_en, if_id_flush, if_id_en, pc_en}
    localparam logic [STB_W-1:0] STB_NORMAL   = 6'b101011;
    localparam logic [STB_W-1:0] STB_FREEZE   = 6'b000000;
    localparam logic [STB_W-1:0] STB_SQUASH   = 6'b111111;
    localparam logic [STB_W-1:0] STB_HOLD     = 6'b010100;
    localparam logic [STB_W-1:0] STB_LOAD_USE = 6'b111000;

endpackage

// File: rtl/pipe_load_use_det.sv
// Combinational load-use comparator: flags an ID instruction that reads the register
// a load currently in EX is about to write. Register 0 never hazards.
module pipe_load_use_det
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_W = 5
) (
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_rw,
    input  logic             ex_md,
    output logic             load_use
);

    // Hit when a live load targets a non-zero register read by ID
    always_comb begin
        load_use = ex_md && ex_rw && (ex_rd != '0) &&
                   ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the IF_ID, ID_EX and EX_MEM pipeline registers.
// Priority each cycle: data-memory wait > EX redirect > load-use.
// Optional stall-cycle perf counter enabled by defining PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_W        = 5,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_rw,
    input  logic             ex_md,
    input  logic             ex_mp,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
`ifdef PIPE_PERF_CNT_EN
    output logic             ex_mem_en,
    output logic [CNT_W-1:0] stall_cnt
`else
    output logic             ex_mem_en
`endif
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD  = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
    localparam bit                     MULTI_FLUSH = (FLUSH_CYCLES > 1);

    pipe_state_t            state_q, state_d;
    logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic                   redir_pend_q, redir_pend_d;
    logic                   resume_q, resume_d;
    logic [STB_W-1:0]       stb;
    logic                   load_use;
    logic                   mem_stall;

    pipe_load_use_det #(
        .REG_W(REG_W)
    ) u_load_use_det (
        .id_rs1    (id_rs1),
        .id_rs2    (id_rs2),
        .id_use_rs1(id_use_rs1),
        .id_use_rs2(id_use_rs2),
        .ex_rd     (ex_rd),
        .ex_rw     (ex_rw),
        .ex_md     (ex_md),
        .load_use  (load_use)
    );

    assign mem_stall = mem_req && !mem_ready;

    // Next-state and Mealy strobe decode; reset overrides strobes to hold the pipe
    always_comb begin
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;
        redir_pend_d = redir_pend_q;
        resume_d     = resume_q;
        stb          = STB_NORMAL;
        unique case (state_q)
            StRun: begin
                if (mem_stall) begin
                    stb          = STB_FREEZE;
                    state_d      = StMemWait;
                    redir_pend_d = ex_mp;
                end else if (ex_mp) begin
                    stb         = STB_SQUASH;
                    flush_cnt_d = FLUSH_LOAD;
                    state_d     = MULTI_FLUSH ? StFlush : StRun;
                end else if (load_use) begin
                    stb = STB_LOAD_USE;
                end
            end
            StMemWait: begin
                if (!mem_ready) begin
                    stb = STB_FREEZE;
                end else if (redir_pend_q) begin
                    // Redirect captured on entry is applied on the release cycle
                    stb          = STB_SQUASH;
                    flush_cnt_d  = FLUSH_LOAD;
                    redir_pend_d = 1'b0;
                    state_d      = MULTI_FLUSH ? StFlush : StRun;
                end else if (resume_q) begin
                    // Release cycle counts as the flush cycle that was frozen
                    stb      = STB_SQUASH;
                    resume_d = 1'b0;
                    if (flush_cnt_q <= FLUSH_CNT_W'(1)) begin
                        flush_cnt_d = '0;
                        state_d     = StRun;
                    end else begin
                        flush_cnt_d = flush_cnt_q - FLUSH_CNT_W'(1);
                        state_d     = StFlush;
                    end
                end else begin
                    state_d = StRun;
                end
            end
            StFlush: begin
                if (mem_stall) begin
                    stb      = STB_FREEZE;
                    resume_d = 1'b1;
                    state_d  = StMemWait;
                end else begin
                    stb = STB_SQUASH;
                    if (flush_cnt_q <= FLUSH_CNT_W'(1)) begin
                        flush_cnt_d = '0;
                        state_d     = StRun;
                    end else begin
                        flush_cnt_d = flush_cnt_q - FLUSH_CNT_W'(1);
                    end
                end
            end
            default: state_d = StRun;
        endcase
        if (!reset) begin
            stb = STB_HOLD;
        end
    end

    // Sequencer state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StRun;
            flush_cnt_q  <= '0;
            redir_pend_q <= 1'b0;
            resume_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_cnt_q  <= flush_cnt_d;
            redir_pend_q <= redir_pend_d;
            resume_q     <= resume_d;
        end
    end

    assign pc_en       = stb[STB_PC_EN];
    assign if_id_en    = stb[STB_IF_ID_EN];
    assign if_id_flush = stb[STB_IF_ID_FLUSH];
    assign id_ex_en    = stb[STB_ID_EX_EN];
    assign id_ex_flush = stb[STB_ID_EX_FLUSH];
    assign ex_mem_en   = stb[STB_EX_MEM_EN];

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;

    // Saturating count of cycles with the PC held
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if (!stb[STB_PC_EN] && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios followed by random traffic.
module tb_pipe_hazard_ctrl;

    localparam int REG_W        = 5;
    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W        = 32;

    // Expected patterns, bit order {ex_mem_en, id_ex_flush, id_ex_en, if_id_flush, if_id_en, pc_en}
    localparam logic [5:0] E_NORMAL = 6'b101011;
    localparam logic [5:0] E_FREEZE = 6'b000000;
    localparam logic [5:0] E_SQUASH = 6'b111111;
    localparam logic [5:0] E_HOLD   = 6'b010100;
    localparam logic [5:0] E_LU     = 6'b111000;

    logic             clk = 1'b0;
    logic             reset;
    logic [REG_W-1:0] id_rs1, id_rs2, ex_rd;
    logic             id_use_rs1, id_use_rs2, ex_rw, ex_md, ex_mp, mem_req, mem_ready;
    logic             pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en;
`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
`endif

    pipe_hazard_ctrl #(
        .REG_W       (REG_W),
        .FLUSH_CYCLES(FLUSH_CYCLES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .ex_rd      (ex_rd),
        .ex_rw      (ex_rw),
        .ex_md      (ex_md),
        .ex_mp      (ex_mp),
        .mem_req    (mem_req),
        .mem_ready  (mem_ready),
        .pc_en      (pc_en),
        .if_id_en   (if_id_en),
        .if_id_flush(if_id_flush),
        .id_ex_en   (id_ex_en),
`ifdef PIPE_PERF_CNT_EN
        .id_ex_flush(id_ex_flush),
        .ex_mem_en  (ex_mem_en),
        .stall_cnt  (stall_cnt)
`else
        .id_ex_flush(id_ex_flush),
        .ex_mem_en  (ex_mem_en)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  strobes;
        longint      cnt;
        string       tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: pending work expressed as plain counts/flags
    int     owed_flushes  = 0;
    bit     waiting       = 0;
    bit     redirect_owed = 0;
    longint stall_model   = 0;

    task automatic model_cycle(input string tag);
        exp_t e;
        bit   stall;
        bit   hit;
        e.tag = tag;
        stall = mem_req && !mem_ready;
        hit   = ex_md && ex_rw && (ex_rd != 0) &&
                ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        if (!reset) begin
            owed_flushes  = 0;
            waiting       = 0;
            redirect_owed = 0;
            stall_model   = 0;
            e.strobes     = E_HOLD;
        end else if (waiting) begin
            if (!mem_ready) begin
                e.strobes = E_FREEZE;
            end else begin
                waiting = 0;
                if (redirect_owed) begin
                    redirect_owed = 0;
                    e.strobes     = E_SQUASH;
                    owed_flushes  = FLUSH_CYCLES - 1;
                end else if (owed_flushes > 0) begin
                    e.strobes    = E_SQUASH;
                    owed_flushes = owed_flushes - 1;
                end else begin
                    e.strobes = E_NORMAL;
                end
            end
        end else if (owed_flushes > 0) begin
            if (stall) begin
                e.strobes = E_FREEZE;
                waiting   = 1;
            end else begin
                e.strobes    = E_SQUASH;
                owed_flushes = owed_flushes - 1;
            end
        end else if (stall) begin
            e.strobes     = E_FREEZE;
            waiting       = 1;
            redirect_owed = ex_mp;
        end else if (ex_mp) begin
            e.strobes    = E_SQUASH;
            owed_flushes = FLUSH_CYCLES - 1;
        end else if (hit) begin
            e.strobes = E_LU;
        end else begin
            e.strobes = E_NORMAL;
        end
        e.cnt = stall_model;
        if (reset && !e.strobes[0] && stall_model < 64'hFFFF_FFFF) stall_model = stall_model + 1;
        sb_q.push_back(e);
    endtask

    task automatic drive(input logic rst, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                         input logic rw, input logic md, input logic mp,
                         input logic mreq, input logic mrdy, input string tag);
        @(negedge clk);
        reset      = rst;
        id_rs1     = rs1;
        id_use_rs1 = u1;
        id_rs2     = rs2;
        id_use_rs2 = u2;
        ex_rd      = rd;
        ex_rw      = rw;
        ex_md      = md;
        ex_mp      = mp;
        mem_req    = mreq;
        mem_ready  = mrdy;
        model_cycle(tag);
    endtask

    task automatic quiet(input string tag);
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    task automatic rand_cycle(input logic rst, input string tag);
        drive(rst, 5'($urandom_range(3, 0)), 1'($urandom), 5'($urandom_range(3, 0)),
              1'($urandom), 5'($urandom_range(3, 0)), 1'($urandom), 1'($urandom),
              1'($urandom_range(6, 0) == 0), 1'($urandom_range(2, 0) == 0), 1'($urandom),
              tag);
    endtask

    // Monitor: compares every cycle's strobes against the oldest expectation
    initial begin
        exp_t       e;
        logic [5:0] got;
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                got = {ex_mem_en, id_ex_flush, id_ex_en, if_id_flush, if_id_en, pc_en};
                n_checks++;
                if (got === e.strobes) n_pass++;
                else $display("FAIL %s: strobes got %b expected %b at %0t", e.tag, got,
                              e.strobes, $time);
`ifdef PIPE_PERF_CNT_EN
                n_checks++;
                if (longint'(stall_cnt) == e.cnt) n_pass++;
                else $display("FAIL %s_cnt: stall_cnt got %0d expected %0d", e.tag,
                              stall_cnt, e.cnt);
`endif
            end
        end
    end

    initial begin
        reset = 1'b0;
        {id_rs1, id_rs2, ex_rd} = '0;
        {id_use_rs1, id_use_rs2, ex_rw, ex_md, ex_mp, mem_req, mem_ready} = '0;

        // Reset held with random inputs, then release
        for (int i = 0; i < 3; i++) rand_cycle(1'b0, "reset_hold");
        quiet("release");

        // Load-use hazard and its non-hazard variants
        drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "load_use");
        quiet("after_lu");
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "lu_rd0");
        drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "lu_rw0");
        drive(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "lu_rs2");

        // Redirect pulse
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "redir");
        quiet("redir_flush2");
        quiet("redir_done");

        // Memory wait with a redirect in its first cycle
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "mw_redir");
        for (int i = 0; i < 2; i++)
            drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "mw_frozen");
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "mw_release");
        quiet("mw_flush2");
        quiet("mw_done");

        // Reset during a memory wait abandons the pending redirect
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "mw2_enter");
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "mw2_frozen");
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "mw2_reset");
        quiet("mw2_after");
        quiet("mw2_after2");

        // Memory wait in the middle of a flush sequence
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "fl_redir");
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "fl_freeze");
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "fl_resume");
        quiet("fl_done");

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) rand_cycle(1'($urandom_range(99, 0) != 0), "random");

        @(negedge clk);
        #4;
        n_checks++;
        if (sb_q.size() == 0) n_pass++;
        else $display("FAIL drain: pending got %0d expected 0", sb_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
